// File: rtl/rates_pack.sv
// Shared definitions for the rates datapath: default wide-bus width, the
// unpacker state type and the eop last-slice/empty computation.
package rates_pack;

  localparam int DATA_WIDTH_IN_BYTES = 16;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEND = 1'b1
  } rates_unpacker_state_t;

  typedef struct packed {
    logic [15:0] last;
    logic [15:0] empty;
  } rates_slice_info_t;

  // valid_bytes of 0 cannot occur for power-of-two widths; it is clamped to 1
  // so the subtraction below never wraps.
  function automatic rates_slice_info_t rates_last_slice(input int unsigned valid_bytes,
                                                         input int unsigned out_bytes);
    rates_slice_info_t info;
    int unsigned v;
    int unsigned l;
    v          = (valid_bytes == 0) ? 1 : valid_bytes;
    l          = (v - 1) / out_bytes;
    info.last  = 16'(l);
    info.empty = 16'((l + 1) * out_bytes - v);
    return info;
  endfunction

endpackage

// File: rtl/rates_unpacker_slice_sel.sv
// Combinational selection of one OUT_BYTES slice from a held IN_BYTES beat.
module rates_unpacker_slice_sel #(
  parameter int IN_BYTES  = 16,
  parameter int OUT_BYTES = 4
) (
  input  logic [IN_BYTES*8-1:0]                                                  data,
  input  logic [((IN_BYTES/OUT_BYTES) > 1 ? $clog2(IN_BYTES/OUT_BYTES) : 1)-1:0] idx,
  output logic [OUT_BYTES*8-1:0]                                                 slice
);

  localparam int RATIO = IN_BYTES / OUT_BYTES;
  localparam int IDXW  = (RATIO > 1) ? $clog2(RATIO) : 1;

  always_comb begin
    slice = '0;
    for (int i = 0; i < RATIO; i++) begin
      if (idx == IDXW'(i)) slice = data[i*OUT_BYTES*8 +: OUT_BYTES*8];
    end
  end

endmodule

// File: rtl/rates_unpacker.sv
// Wide-to-narrow stream converter: one held IN_BYTES beat re-emitted as OUT_BYTES slices.
// Optional message counter on output eop transfers: RATES_UNPACKER_MSG_CNT_EN.
//
// state | meaning
// IDLE  | no beat held
// SEND  | beat held, slice idx presented on the output
module rates_unpacker
  import rates_pack::*;
#(
  parameter int IN_BYTES  = DATA_WIDTH_IN_BYTES,
  parameter int OUT_BYTES = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [IN_BYTES*8-1:0]        in_data,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic                         in_sop,
  input  logic                         in_eop,
  input  logic [$clog2(IN_BYTES)-1:0]  in_empty,
  output logic [OUT_BYTES*8-1:0]       out_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic                         out_sop,
  output logic                         out_eop,
  output logic [$clog2(OUT_BYTES)-1:0] out_empty
`ifdef RATES_UNPACKER_MSG_CNT_EN
  ,
  output logic [31:0]                  msg_count
`endif
);

  localparam int RATIO = IN_BYTES / OUT_BYTES;
  localparam int IDXW  = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam int EW    = $clog2(OUT_BYTES);
  localparam logic [IDXW-1:0] LAST_FULL = IDXW'(RATIO - 1);

  if (OUT_BYTES < 2 || (IN_BYTES % OUT_BYTES) != 0) begin : g_bad_cfg
    $error("rates_unpacker: OUT_BYTES must be >= 2 and divide IN_BYTES");
  end

  rates_unpacker_state_t state;
  logic [IN_BYTES*8-1:0] held_data;
  logic                  held_sop;
  logic                  held_eop;
  logic [IDXW-1:0]       last;
  logic [EW-1:0]         last_empty;
  logic [IDXW-1:0]       idx;

  rates_slice_info_t     load_info;
  logic [IDXW-1:0]       load_last;
  logic [EW-1:0]         load_empty;
  logic                  in_xfer;
  logic                  out_xfer;
  logic                  at_last;

  // Last slice and its empty count are resolved at load time so the output
  // side only ever compares idx against a register.
  always_comb begin
    load_info  = rates_last_slice(unsigned'(IN_BYTES - int'(in_empty)), unsigned'(OUT_BYTES));
    load_last  = in_eop ? load_info.last[IDXW-1:0] : LAST_FULL;
    load_empty = in_eop ? load_info.empty[EW-1:0] : '0;
  end

  assign at_last   = (idx == last);
  assign out_valid = (state == SEND);
  assign in_ready  = !rst && ((state == IDLE) || (at_last && out_ready));
  assign in_xfer   = in_valid && in_ready;
  assign out_xfer  = out_valid && out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      held_data  <= '0;
      held_sop   <= 1'b0;
      held_eop   <= 1'b0;
      last       <= '0;
      last_empty <= '0;
      idx        <= '0;
    end else if (in_xfer) begin
      state      <= SEND;
      held_data  <= in_data;
      held_sop   <= in_sop;
      held_eop   <= in_eop;
      last       <= load_last;
      last_empty <= load_empty;
      idx        <= '0;
    end else if (out_xfer) begin
      if (at_last) begin
        state <= IDLE;
        idx   <= '0;
      end else begin
        idx <= idx + 1'b1;
      end
    end
  end

  rates_unpacker_slice_sel #(
    .IN_BYTES  (IN_BYTES),
    .OUT_BYTES (OUT_BYTES)
  ) u_slice_sel (
    .data  (held_data),
    .idx   (idx),
    .slice (out_data)
  );

  assign out_sop   = out_valid && held_sop && (idx == '0);
  assign out_eop   = out_valid && held_eop && at_last;
  assign out_empty = out_eop ? last_empty : '0;

`ifdef RATES_UNPACKER_MSG_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                      msg_count <= '0;
    else if (out_xfer && out_eop) msg_count <= msg_count + 32'd1;
  end
`endif

endmodule

// File: tb/tb_rates_unpacker.sv
// Scoreboard bench for rates_unpacker (IN_BYTES=16, OUT_BYTES=4); covers
// msg_count when RATES_UNPACKER_MSG_CNT_EN is defined.
module tb_rates_unpacker;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [127:0] in_data = '0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic         in_sop = 1'b0;
  logic         in_eop = 1'b0;
  logic [3:0]   in_empty = '0;
  logic [31:0]  out_data;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic         out_sop;
  logic         out_eop;
  logic [1:0]   out_empty;
`ifdef RATES_UNPACKER_MSG_CNT_EN
  logic [31:0]  msg_count;
`endif

  rates_unpacker #(.IN_BYTES(16), .OUT_BYTES(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sop    (in_sop),
    .in_eop    (in_eop),
    .in_empty  (in_empty),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sop   (out_sop),
    .out_eop   (out_eop),
    .out_empty (out_empty)
`ifdef RATES_UNPACKER_MSG_CNT_EN
    ,
    .msg_count (msg_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic        sop;
    logic        eop;
    logic [1:0]  empty;
    logic        lastslice;
  } exp_t;

  exp_t q[$];
  int passed = 0;
  int total = 0;
  int cyc = 0;
  int pop_cnt = 0;
  int first_cyc = 0;
  int last_cyc = 0;
  int ready_viol = 0;

  task automatic chk(input bit ok, input string name, input logic [63:0] act, input logic [63:0] expv);
    total++;
    if (ok) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
  endtask

  function automatic logic [127:0] pattern(input logic [7:0] base);
    logic [127:0] d;
    for (int i = 0; i < 16; i++) d[i*8 +: 8] = base + 8'(i);
    return d;
  endfunction

  // Expected slices: ceil(valid/4) slices, padding of the final one is the empty count.
  task automatic push_beat(input logic [127:0] d, input logic sop, input logic eop, input logic [3:0] empty);
    int   valid;
    int   nsl;
    int   pad;
    exp_t e;
    valid = eop ? 16 - int'(empty) : 16;
    nsl   = (valid + 3) / 4;
    pad   = nsl * 4 - valid;
    for (int s = 0; s < nsl; s++) begin
      e.data      = d[s*32 +: 32];
      e.sop       = sop && (s == 0);
      e.eop       = eop && (s == nsl - 1);
      e.empty     = (eop && s == nsl - 1) ? 2'(pad) : 2'd0;
      e.lastslice = (s == nsl - 1);
      q.push_back(e);
    end
  endtask

  task automatic send_beat(input logic [127:0] d, input logic sop, input logic eop, input logic [3:0] empty);
    bit got;
    push_beat(d, sop, eop, empty);
    in_data  = d;
    in_sop   = sop;
    in_eop   = eop;
    in_empty = empty;
    in_valid = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (in_ready) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) chk(1'b0, "accept_timeout", 64'd0, 64'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_sop   = 1'b0;
    in_eop   = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 1000; i++) begin
      @(posedge clk);
      #2;
      if (q.size() == 0 && !out_valid) break;
    end
    chk(q.size() == 0 && !out_valid, name, 64'(q.size()), 64'd0);
  endtask

  always @(posedge clk) cyc = cyc + 1;

  always @(negedge clk) begin
    exp_t e;
    if (!rst && out_valid) begin
      if (q.size() == 0) begin
        chk(1'b0, "unexpected_slice", {28'd0, out_data, out_sop, out_eop, out_empty}, 64'd0);
      end else begin
        e = q[0];
        chk(out_data == e.data && out_sop == e.sop && out_eop == e.eop && out_empty == e.empty,
            "slice", {28'd0, out_data, out_sop, out_eop, out_empty},
            {28'd0, e.data, e.sop, e.eop, e.empty});
        if (in_ready && !e.lastslice) ready_viol++;
        if (out_ready) begin
          void'(q.pop_front());
          pop_cnt++;
          if (pop_cnt == 1) first_cyc = cyc;
          last_cyc = cyc;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk(out_valid == 1'b0, "rst_out_valid", 64'(out_valid), 64'd0);
    chk(in_ready == 1'b0, "rst_in_ready", 64'(in_ready), 64'd0);
    chk(out_data == 32'd0, "rst_out_data", 64'(out_data), 64'd0);
    chk(out_sop == 1'b0, "rst_out_sop", 64'(out_sop), 64'd0);
    chk(out_eop == 1'b0, "rst_out_eop", 64'(out_eop), 64'd0);
    chk(out_empty == 2'd0, "rst_out_empty", 64'(out_empty), 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk(in_ready == 1'b1, "idle_in_ready", 64'(in_ready), 64'd1);

    // two-beat message
    @(posedge clk);
    #1 pop_cnt = 0;
    send_beat(pattern(8'h00), 1'b1, 1'b0, 4'd0);
    send_beat(pattern(8'h10), 1'b0, 1'b1, 4'd0);
    wait_drain("drain_two_beat");
    chk(pop_cnt == 8, "two_beat_slices", 64'(pop_cnt), 64'd8);
    chk(last_cyc - first_cyc + 1 == pop_cnt, "two_beat_gaps", 64'(last_cyc - first_cyc + 1), 64'(pop_cnt));

    // single-beat message, 11 valid bytes
    pop_cnt = 0;
    send_beat(pattern(8'h40), 1'b1, 1'b1, 4'd5);
    wait_drain("drain_single");
    chk(pop_cnt == 3, "single_slices", 64'(pop_cnt), 64'd3);

    // continuous stream of four beats
    pop_cnt = 0;
    ready_viol = 0;
    send_beat(pattern(8'h50), 1'b1, 1'b0, 4'd0);
    send_beat(pattern(8'h60), 1'b0, 1'b0, 4'd0);
    send_beat(pattern(8'h70), 1'b0, 1'b0, 4'd0);
    send_beat(pattern(8'hC0), 1'b0, 1'b1, 4'd0);
    wait_drain("drain_stream");
    chk(pop_cnt == 16, "stream_slices", 64'(pop_cnt), 64'd16);
    chk(last_cyc - first_cyc + 1 == pop_cnt, "stream_gaps", 64'(last_cyc - first_cyc + 1), 64'(pop_cnt));
    chk(ready_viol == 0, "stream_in_ready_last_only", 64'(ready_viol), 64'd0);

    // eop boundaries: 4, 1, 12 and 16 valid bytes
    pop_cnt = 0;
    send_beat(pattern(8'hD0), 1'b1, 1'b1, 4'd12);
    send_beat(pattern(8'hE0), 1'b1, 1'b1, 4'd15);
    send_beat(pattern(8'hF0), 1'b1, 1'b1, 4'd4);
    send_beat(pattern(8'h20), 1'b1, 1'b1, 4'd0);
    wait_drain("drain_boundary");
    chk(pop_cnt == 9, "boundary_slices", 64'(pop_cnt), 64'd9);
    chk(last_cyc - first_cyc + 1 == pop_cnt, "boundary_gaps", 64'(last_cyc - first_cyc + 1), 64'(pop_cnt));

    // stall 10 cycles after the first slice, then toggle out_ready
    pop_cnt = 0;
    fork
      begin
        send_beat(pattern(8'h80), 1'b1, 1'b0, 4'd0);
        send_beat(pattern(8'h90), 1'b0, 1'b1, 4'd2);
      end
      begin
        for (int i = 0; i < 100 && pop_cnt < 1; i++) @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (10) @(posedge clk);
        for (int i = 0; i < 12; i++) begin
          #1 out_ready = ~out_ready;
          @(posedge clk);
        end
        #1 out_ready = 1'b1;
      end
    join
    wait_drain("drain_stall");
    chk(pop_cnt == 8, "stall_slices", 64'(pop_cnt), 64'd8);

    // reset after two slices of a four-slice beat
    pop_cnt = 0;
    send_beat(pattern(8'hA0), 1'b1, 1'b0, 4'd0);
    for (int i = 0; i < 100 && pop_cnt < 2; i++) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk(out_valid == 1'b0, "midrst_out_valid", 64'(out_valid), 64'd0);
    chk(out_eop == 1'b0, "midrst_out_eop", 64'(out_eop), 64'd0);
    chk(in_ready == 1'b0, "midrst_in_ready", 64'(in_ready), 64'd0);
    q.delete();
    @(negedge clk);
    chk(out_data == 32'd0, "midrst_out_data", 64'(out_data), 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk(in_ready == 1'b1, "post_rst_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1 pop_cnt = 0;
    send_beat(pattern(8'hB0), 1'b1, 1'b1, 4'd0);
    wait_drain("drain_post_rst");
    chk(pop_cnt == 4, "post_rst_slices", 64'(pop_cnt), 64'd4);

`ifdef RATES_UNPACKER_MSG_CNT_EN
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    send_beat(pattern(8'h01), 1'b1, 1'b1, 4'd0);
    send_beat(pattern(8'h11), 1'b1, 1'b0, 4'd0);
    send_beat(pattern(8'h21), 1'b0, 1'b1, 4'd9);
    send_beat(pattern(8'h31), 1'b1, 1'b1, 4'd14);
    wait_drain("drain_msg_cnt");
    chk(msg_count == 32'd3, "msg_count_three", 64'(msg_count), 64'd3);
    #1 rst = 1'b1;
    #1;
    chk(msg_count == 32'd0, "msg_count_rst", 64'(msg_count), 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;
`endif

    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/rates_unpacker.md
# rates_unpacker

Wide-to-narrow rate converter for the rates datapath. It accepts message beats of IN_BYTES on a valid/ready stream and re-emits them as OUT_BYTES-wide beats, preserving byte order, sop, eop and the trailing empty-byte count. It is the output-side counterpart of the rates packer (narrow-to-wide) and sits between the wide internal bus and a narrow egress port.

## Interface
- IN_BYTES, default DATA_WIDTH_IN_BYTES (16): input beat width in bytes.
- OUT_BYTES, default 4: output beat width in bytes. Must be ≥2 and divide IN_BYTES. Elaboration fails otherwise.
- RATIO = IN_BYTES/OUT_BYTES: derived localparam, not overridable.
- clk  in  1  single clock for the block.
- rst  in  1  asynchronous, active-high reset.
- in_data  in  IN_BYTES*8  byte 0 in [7:0] is the first byte on the wire.
- in_valid / in_ready  in / out  1  input handshake. A transfer occurs when both are high on a rising edge.
- in_sop / in_eop  in  1  first and last beat of a message.
- in_empty  in  $clog2(IN_BYTES)  unused highest-indexed bytes. Valid only with in_eop and ignored otherwise.
- out_data  out  OUT_BYTES*8  output slice, same byte ordering as in_data.
- out_valid / out_ready  out / in  1  output handshake.
- out_sop / out_eop  out  1  message boundaries on the narrow side.
- out_empty  out  $clog2(OUT_BYTES)  unused highest bytes on the out_eop beat. It is 0 on all other beats.
- msg_count  out  32  present only with RATES_UNPACKER_MSG_CNT_EN.

## Operation
- Holding register stores one accepted wide beat: data, sop, eop, and last-slice index `last`. A slice counter `idx` selects slice idx = bytes [idx*OUT_BYTES +: OUT_BYTES].
- State machine:
  - IDLE: no beat held.
  - SEND: beat held; slice idx is presented.
- Transitions:
  - IDLE→SEND on an input transfer.
  - SEND→SEND on an output transfer with idx<last (idx+1).
  - SEND→SEND on an output transfer with idx==last and a simultaneous input transfer (load new beat, idx=0).
  - SEND→IDLE on an output transfer with idx==last and no input transfer.
- in_ready = !rst && (state==IDLE || (idx==last && out_ready)). This is combinational from out_ready and gives full throughput.
- last slice index:
  - Non-eop beat: last = RATIO-1.
  - eop beat: valid = IN_BYTES-in_empty, last = (valid-1)/OUT_BYTES, and out_empty on that slice = (last+1)*OUT_BYTES - valid.
  - Compute both at load time.
- out_sop = held sop && idx==0. out_eop = held eop && idx==last.
- Slices beyond last in an eop beat are never emitted.
- sop and eop in the same input beat form a one-beat message. It emits 1..RATIO slices; the first carries sop and the last carries eop.
- Output stability: while out_valid && !out_ready, out_data, out_sop, out_eop and out_empty hold constant.
- The block never checks message framing. A missing sop or eop passes through as received.
- Reset, including mid-message: asynchronous return to IDLE and idx=0. The held beat is discarded; no partial or terminating eop is generated.

## Timing
- Reset values: out_valid 0, out_data 0, out_sop 0, out_eop 0, out_empty 0, in_ready 0 while rst is high, msg_count 0.
- Latency: input transfer at edge N gives out_valid high after edge N, so slice 0 is available in cycle N+1.
- Throughput: one OUT_BYTES slice per cycle. A full beat occupies RATIO cycles; an eop beat occupies last+1 cycles.
- Back-to-back beats with out_ready held high give no bubbles.
- in_ready is high in IDLE, which is the first cycle after rst deasserts.

## Configuration
- RATES_UNPACKER_MSG_CNT_EN defined:
  - msg_count is a 32-bit counter incremented on each output transfer with out_eop=1.
  - It wraps from 0xFFFF_FFFF to 0 and resets to 0.
- Macro undefined: the msg_count port and the counter are absent. Datapath behaviour is identical.

## Structure
- Shared package rates_pack holds:
  - DATA_WIDTH_IN_BYTES, the default IN_BYTES.
  - The state enum typedef rates_unpacker_state_t {IDLE, SEND}.
  - Function rates_last_slice(valid_bytes, out_bytes) returning the last index and empty count.
- One sub-module, rates_unpacker_slice_sel: combinational mux from the held beat plus idx to out_data. Parameterised by IN_BYTES and OUT_BYTES.

## Test plan
Use IN_BYTES=16, OUT_BYTES=4 unless stated.
- Two-beat message (sop beat, then eop beat with in_empty=0), out_ready=1 → 8 output beats in byte order. sop on beat 1, eop on beat 8 with out_empty=0, no gaps.
- Single-beat message (sop+eop, in_empty=5, 11 valid bytes) → 3 slices. The third carries out_eop=1 and out_empty=1; no 4th slice.
- Continuous input with out_ready=1 → out_valid never drops. in_ready is high only on last-slice cycles, one wide beat per 4 cycles.
- out_ready held low 10 cycles mid-beat, then toggled 1010… → outputs stable while stalled, no slice lost or duplicated (scoreboard byte-exact).
- rst asserted after 2 slices of a 4-slice beat → out_valid 0 immediately and no eop emitted. The next message starts clean with sop on slice 0.
- With RATES_UNPACKER_MSG_CNT_EN, send 3 messages → msg_count 3. rst → msg_count 0.
